// File: rtl/circular_dma_reader.sv
// Circular-buffer DMA reader: issues AXI read bursts for the data a producer
// has written into a ring buffer and streams the beats out over AXI-Stream
// through a local FIFO. One burst in flight at a time; FIFO space for a burst
// is reserved before its AR is issued, so R is never back-pressured.
//
// Handshakes: a transfer happens on a channel in the cycle where both valid
// and ready are 1 at the rising clock edge. Valid never depends on ready, and
// once valid is raised the payload holds until the transfer completes.
module circular_dma_reader #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_MAX_BURST  = 16,
  parameter int C_FIFO_DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [C_ADDR_WIDTH-1:0] mem_base,
  input  logic [C_ADDR_WIDTH-1:0] mem_size,
  input  logic [C_ADDR_WIDTH-1:0] mem_wr_ptr,
  output logic [C_ADDR_WIDTH-1:0] mem_rd_ptr,
  output logic                    busy,
  output logic                    error,
  output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [C_AXIS_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [C_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam int B   = C_AXIS_WIDTH / 8;
  localparam int BSH = $clog2(B);
  localparam int FAW = $clog2(C_FIFO_DEPTH);

  localparam logic [FAW:0]          CNT_ONE   = (FAW+1)'(1);
  localparam logic [FAW-1:0]        IDX_ONE   = FAW'(1);
  localparam logic [FAW:0]          DEPTH_C   = (FAW+1)'(C_FIFO_DEPTH);
  localparam logic [C_ADDR_WIDTH-1:0] BEAT_MASK = ~(C_ADDR_WIDTH'(B - 1));
  localparam logic [C_ADDR_WIDTH-1:0] MAXB_C    = C_ADDR_WIDTH'(C_MAX_BURST);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state;
  state_t state_next;

  logic [C_ADDR_WIDTH-1:0] rd_ptr;
  logic [C_ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]              arlen_q;
  logic [8:0]              len_q;
  logic [8:0]              beat_cnt;
  logic                    error_q;

  // burst sizing
  logic [C_ADDR_WIDTH-1:0] wr_al;
  logic [C_ADDR_WIDTH-1:0] avail;
  logic [C_ADDR_WIDTH-1:0] beats_avail;
  logic [C_ADDR_WIDTH-1:0] beats_to_end;
  logic [C_ADDR_WIDTH-1:0] beats_free;
  logic [C_ADDR_WIDTH-1:0] len_calc;
  logic [C_ADDR_WIDTH-1:0] next_ptr;
  logic                    beat_last;

  // fifo
  logic [C_AXIS_WIDTH-1:0] fifo_mem [C_FIFO_DEPTH];
  logic [FAW-1:0]          wr_idx;
  logic [FAW-1:0]          rd_idx;
  logic [FAW:0]            count;
  logic                    push;
  logic                    pop;

  // Burst length: bounded by data available, the burst cap, the distance to the
  // end of the ring (a burst never wraps) and the free FIFO slots.
  always_comb begin
    wr_al        = mem_wr_ptr & BEAT_MASK;
    avail        = (wr_al >= rd_ptr) ? (wr_al - rd_ptr) : (mem_size - rd_ptr + wr_al);
    beats_avail  = avail >> BSH;
    beats_to_end = (mem_size - rd_ptr) >> BSH;
    beats_free   = C_ADDR_WIDTH'(DEPTH_C - count);
    len_calc     = beats_avail;
    if (MAXB_C < len_calc)       len_calc = MAXB_C;
    if (beats_to_end < len_calc) len_calc = beats_to_end;
    if (beats_free < len_calc)   len_calc = beats_free;
    next_ptr     = rd_ptr + (C_ADDR_WIDTH'(len_q) << BSH);
    if (next_ptr == mem_size)    next_ptr = '0;
    beat_last    = m_axi_rvalid && (m_axi_rlast || (beat_cnt == len_q - 9'd1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: start when there is something to fetch, then AR, then R beats.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && (len_calc != '0)) state_next = ADDR;
      ADDR:    if (m_axi_arready)              state_next = DATA;
      DATA:    if (beat_last)                  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst bookkeeping: latch the request, count beats, advance the read pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!enable) begin
            rd_ptr <= '0;
          end else if (len_calc != '0) begin
            araddr_q <= mem_base + rd_ptr;
            arlen_q  <= 8'(len_calc - C_ADDR_WIDTH'(1));
            len_q    <= len_calc[8:0];
            beat_cnt <= '0;
          end
        end
        DATA: begin
          if (m_axi_rvalid) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (m_axi_rresp != 2'b00) error_q <= 1'b1;
            if (beat_last) rd_ptr <= next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

  assign push = (state == DATA) && m_axi_rvalid;
  assign pop  = (count != '0) && m_axis_tready;

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= m_axi_rdata;
  end

  // FIFO pointers and occupancy, push and pop may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + IDX_ONE;
      if (pop)  rd_idx <= rd_idx + IDX_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign mem_rd_ptr    = rd_ptr;
  assign busy          = (state != IDLE);
  assign error         = error_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = (state == ADDR);
  assign m_axi_rready  = (state == DATA);
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = fifo_mem[rd_idx];

endmodule

// File: tb/tb_circular_dma_reader.sv
// Directed bench for circular_dma_reader: a small AXI read slave returns an
// address-derived pattern, and every output beat is checked against a queue of
// hand-computed expected words.
module tb_circular_dma_reader;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] SIZE = 32'h0000_0400;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] mem_base;
  logic [31:0] mem_size;
  logic [31:0] mem_wr_ptr;
  logic [31:0] mem_rd_ptr;
  logic        busy;
  logic        error;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  int total = 0;
  int bad   = 0;
  int err_beat = -1;
  logic hold_ar = 1'b0;

  logic [63:0] exp_q[$];
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];

  circular_dma_reader dut (
    .clk(clk), .rst(rst), .enable(enable),
    .mem_base(mem_base), .mem_size(mem_size), .mem_wr_ptr(mem_wr_ptr),
    .mem_rd_ptr(mem_rd_ptr), .busy(busy), .error(error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] off, input int beats);
    for (int i = 0; i < beats; i++) exp_q.push_back(pat(BASE + off + 32'(i * 8)));
  endtask

  task automatic wait_rd_ptr(input logic [31:0] v, input string tag);
    int n = 0;
    while (mem_rd_ptr !== v && n < 3000) begin @(negedge clk); n++; end
    check(tag, mem_rd_ptr, v);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_arcount(input int c, input string tag);
    int n = 0;
    while (ar_addr_q.size() < c && n < 3000) begin @(negedge clk); n++; end
    check(tag, 64'(ar_addr_q.size()), 64'(c));
  endtask

  // sel: 0 busy==0, 1 rready==1, 2 arvalid==1
  task automatic wait_sig(input int sel, input string tag);
    int n = 0;
    logic hit;
    hit = 1'b0;
    while (!hit && n < 3000) begin
      case (sel)
        0:       hit = !busy;
        1:       hit = m_axi_rready;
        default: hit = m_axi_arvalid;
      endcase
      if (!hit) begin @(negedge clk); n++; end
    end
    check(tag, 64'(hit), 64'd1);
  endtask

  // AXI read slave: accept AR one cycle after arvalid, then one beat per cycle.
  initial begin
    logic [31:0] a;
    int          l;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rresp   = 2'b00;
    m_axi_rdata   = '0;
    forever begin
      @(negedge clk);
      if (!hold_ar && !rst && m_axi_arvalid) begin
        a = m_axi_araddr;
        l = int'(m_axi_arlen);
        ar_addr_q.push_back(a);
        ar_len_q.push_back(m_axi_arlen);
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        for (int i = 0; i <= l; i++) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = pat(a + 32'(i * 8));
          m_axi_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (i == l);
          @(negedge clk);
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
    end
  end

  // Scoreboard: every accepted output beat must match the head of exp_q.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) check("extra_beat", m_axis_tdata, 64'd0);
        else                   check("tdata", m_axis_tdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0;
    mem_base = BASE; mem_size = SIZE; mem_wr_ptr = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_rd_ptr", mem_rd_ptr, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_araddr", m_axi_araddr, 0);
    check("rst_arlen", m_axi_arlen, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic: 16 beats from the start of the buffer
    push_exp(32'h0, 16);
    mem_wr_ptr = 32'h80; enable = 1'b1;
    wait_rd_ptr(32'h80, "basic_rd_ptr");
    wait_drain("basic_drain");
    repeat (10) @(negedge clk);
    check("basic_ar_count", ar_addr_q.size(), 1);
    check("basic_araddr", ar_addr_q[0], BASE);
    check("basic_arlen", ar_len_q[0], 15);
    check("basic_busy", busy, 0);

    // advance to 0x3C0: six 16-beat bursts and one 8-beat burst
    ar_addr_q.delete(); ar_len_q.delete();
    push_exp(32'h80, 104);
    mem_wr_ptr = 32'h3C0;
    wait_rd_ptr(32'h3C0, "pre_wrap_rd_ptr");
    wait_drain("pre_wrap_drain");
    check("pre_wrap_ar_count", ar_addr_q.size(), 7);
    check("pre_wrap_last_arlen", ar_len_q[6], 7);

    // wrap: tail burst to the end of the ring, then from the base
    ar_addr_q.delete(); ar_len_q.delete();
    push_exp(32'h3C0, 8);
    push_exp(32'h0, 8);
    mem_wr_ptr = 32'h40;
    wait_rd_ptr(32'h0, "wrap_rd_ptr_zero");
    wait_rd_ptr(32'h40, "wrap_rd_ptr_end");
    wait_drain("wrap_drain");
    check("wrap_ar_count", ar_addr_q.size(), 2);
    check("wrap_araddr0", ar_addr_q[0], 32'h1000_03C0);
    check("wrap_arlen0", ar_len_q[0], 7);
    check("wrap_araddr1", ar_addr_q[1], BASE);
    check("wrap_arlen1", ar_len_q[1], 7);

    // backpressure: FIFO fills after four bursts and issuing stops
    ar_addr_q.delete(); ar_len_q.delete();
    push_exp(32'h40, 88);
    m_axis_tready = 1'b0;
    mem_wr_ptr = 32'h300;
    wait_arcount(4, "bp_ar4");
    wait_rd_ptr(32'h240, "bp_rd_ptr_full");
    repeat (30) @(negedge clk);
    check("bp_no_5th_ar", ar_addr_q.size(), 4);
    check("bp_tvalid_full", m_axis_tvalid, 1);
    check("bp_busy", busy, 0);
    // producer pauses (avail=0) while the consumer pops 16 beats
    mem_wr_ptr = 32'h240;
    m_axis_tready = 1'b1;
    repeat (16) @(negedge clk);
    m_axis_tready = 1'b0;
    repeat (5) @(negedge clk);
    check("bp_paused_ar_count", ar_addr_q.size(), 4);
    mem_wr_ptr = 32'h300;
    wait_arcount(5, "bp_ar5");
    check("bp_araddr5", ar_addr_q[4], 32'h1000_0240);
    check("bp_arlen5", ar_len_q[4], 15);
    m_axis_tready = 1'b1;
    wait_rd_ptr(32'h300, "bp_rd_ptr_end");
    wait_drain("bp_drain");

    // error response on the third beat
    ar_addr_q.delete(); ar_len_q.delete();
    check("pre_err_error", error, 0);
    err_beat = 2;
    push_exp(32'h300, 16);
    mem_wr_ptr = 32'h380;
    wait_rd_ptr(32'h380, "err_rd_ptr");
    wait_drain("err_drain");
    check("err_flag", error, 1);
    check("err_araddr", ar_addr_q[0], 32'h1000_0300);
    check("err_arlen", ar_len_q[0], 15);
    err_beat = -1;

    // enable drop during DATA: burst completes, then pointer clears
    ar_addr_q.delete(); ar_len_q.delete();
    push_exp(32'h380, 8);
    mem_wr_ptr = 32'h3C0;
    wait_sig(1, "en_wait_data");
    enable = 1'b0;
    wait_sig(0, "en_wait_idle");
    check("en_burst_done_ptr", mem_rd_ptr, 32'h3C0);
    @(negedge clk);
    check("en_ptr_cleared", mem_rd_ptr, 0);
    wait_drain("en_drain");
    repeat (10) @(negedge clk);
    check("en_ar_count", ar_addr_q.size(), 1);
    check("en_error_sticky", error, 1);
    check("en_rd_ptr_held", mem_rd_ptr, 0);

    // reset while the AR is waiting for arready
    hold_ar = 1'b1;
    mem_wr_ptr = 32'h80; enable = 1'b1;
    wait_sig(2, "rst_wait_addr");
    check("addr_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_arvalid", m_axi_arvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rready", m_axi_rready, 0);
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_rd_ptr", mem_rd_ptr, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_araddr", m_axi_araddr, 0);
    check("mid_rst_arlen", m_axi_arlen, 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_ar = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_extra_ar", ar_addr_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
